traffic_sensor_q: RTL and testbench

TRAFFIC_SENSOR_Q -- requirements
Module: traffic_sensor_q

---
 rtl/traffic_sensor_q_if.sv | 28 ++
 rtl/traffic_sensor_q.sv | 156 +++++++++++++++
 tb/tb_traffic_sensor_q.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_sensor_q_if.sv
// Sensor <-> controller/environment bundle for traffic_sensor_q.
// master: drives arrivals and lights; slave: the sensor, returns
// traffic-present flags, queue counts and sticky fault flags.
interface traffic_sensor_q_if #(
    parameter int CNT_W = 4
);
    logic             arr_a;
    logic             arr_b;
    logic [1:0]       la;
    logic [1:0]       lb;
    logic             ta;
    logic             tb;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;
    logic             ovf_a;
    logic             ovf_b;
    logic             err;

    modport master (
        output arr_a, arr_b, la, lb,
        input  ta, tb, cnt_a, cnt_b, ovf_a, ovf_b, err
    );

    modport slave (
        input  arr_a, arr_b, la, lb,
        output ta, tb, cnt_a, cnt_b, ovf_a, ovf_b, err
    );
endinterface

// File: rtl/traffic_sensor_q.sv
// Two-road vehicle queue sensor feeding a traffic light controller.
// Ports: clk, rst (sync, active-low), bus (traffic_sensor_q_if.slave).

// One road: queue counter, departure timer and EMPTY/WAITING/DEPARTING.
// Ports: clk, rst, arr pulse, light code in; cnt and sticky ovf out.
module traffic_sensor_q_road #(
    parameter int CNT_W      = 4,
    parameter int DEP_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arr,
    input  logic [1:0]       light,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);
    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        WAITING   = 2'd1,
        DEPARTING = 2'd2
    } road_st_e;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [3:0]       TMR_LAST = 4'(DEP_CYCLES - 1);

    road_st_e         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       tmr_q, tmr_d;
    logic             ovf_q, ovf_d;
    logic             green;
    logic             run;
    logic             dep;

    always_comb begin
        // Only 2'b00 is green; yellow, red and the illegal code all stall.
        green = (light == 2'b00);
        // A non-empty queue under green spends this cycle departing.
        run   = (state_q != EMPTY) && green;
        dep   = run && (tmr_q == TMR_LAST);

        cnt_d = cnt_q;
        ovf_d = ovf_q;
        tmr_d = (run && !dep) ? tmr_q + 4'd1 : 4'd0;

        // Arrival and departure together cancel, so a full queue
        // never loses that arrival.
        if (arr && !dep) begin
            if (cnt_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (dep && !arr) begin
            cnt_d = cnt_q - CNT_ONE;
        end

        unique case (state_q)
            EMPTY: begin
                state_d = arr ? WAITING : EMPTY;
            end
            WAITING, DEPARTING: begin
                if (cnt_d == '0) begin
                    state_d = EMPTY;
                end else if (green) begin
                    state_d = DEPARTING;
                end else begin
                    state_d = WAITING;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= EMPTY;
            cnt_q   <= '0;
            tmr_q   <= 4'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            ovf_q   <= ovf_d;
        end
    end

    assign cnt = cnt_q;
    assign ovf = ovf_q;
endmodule

module traffic_sensor_q #(
    parameter int CNT_W      = 4,
    parameter int DEP_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    traffic_sensor_q_if.slave     bus
);
    logic [CNT_W-1:0] cnt_a_w;
    logic [CNT_W-1:0] cnt_b_w;
    logic             ovf_a_w;
    logic             ovf_b_w;
    logic             err_q, err_d;

    traffic_sensor_q_road #(
        .CNT_W      (CNT_W),
        .DEP_CYCLES (DEP_CYCLES)
    ) u_road_a (
        .clk   (clk),
        .rst   (rst),
        .arr   (bus.arr_a),
        .light (bus.la),
        .cnt   (cnt_a_w),
        .ovf   (ovf_a_w)
    );

    traffic_sensor_q_road #(
        .CNT_W      (CNT_W),
        .DEP_CYCLES (DEP_CYCLES)
    ) u_road_b (
        .clk   (clk),
        .rst   (rst),
        .arr   (bus.arr_b),
        .light (bus.lb),
        .cnt   (cnt_b_w),
        .ovf   (ovf_b_w)
    );

    always_comb begin
        err_d = err_q
              | (bus.la == 2'b11)
              | (bus.lb == 2'b11)
              | ((bus.la == 2'b00) && (bus.lb == 2'b00));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    // Presence flags come from the count registers only.
    assign bus.ta    = (cnt_a_w != '0);
    assign bus.tb    = (cnt_b_w != '0);
    assign bus.cnt_a = cnt_a_w;
    assign bus.cnt_b = cnt_b_w;
    assign bus.ovf_a = ovf_a_w;
    assign bus.ovf_b = ovf_b_w;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_traffic_sensor_q.sv
// Randomized + directed bench for traffic_sensor_q against a
// queue/green-time reference model.
module tb_traffic_sensor_q;
    localparam int CNT_W = 4;
    localparam int DEP   = 3;
    localparam int MAXC  = (1 << CNT_W) - 1;

    localparam logic [1:0] G = 2'b00;
    localparam logic [1:0] Y = 2'b01;
    localparam logic [1:0] R = 2'b10;
    localparam logic [1:0] X = 2'b11;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    traffic_sensor_q_if #(.CNT_W(CNT_W)) bus ();

    traffic_sensor_q #(
        .CNT_W      (CNT_W),
        .DEP_CYCLES (DEP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference: queue length, green cycles served toward the
    // vehicle at the head, sticky flags.
    int m_cnt  [2];
    int m_green[2];
    bit m_ovf  [2];
    bit m_err;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic road_step(input int i, input bit arr, input logic [1:0] l);
        bit left;
        left = 0;
        if (l == G && m_cnt[i] > 0) begin
            m_green[i] = m_green[i] + 1;
            if (m_green[i] == DEP) begin
                left       = 1;
                m_green[i] = 0;
            end
        end else begin
            m_green[i] = 0;
        end
        m_cnt[i] = m_cnt[i] + int'(arr) - int'(left);
        if (m_cnt[i] > MAXC) begin
            m_cnt[i] = MAXC;
            m_ovf[i] = 1;
        end
    endtask

    task automatic model_step(input bit r, input bit aa, input bit ab,
                              input logic [1:0] a_l, input logic [1:0] b_l);
        if (!r) begin
            for (int i = 0; i < 2; i++) begin
                m_cnt[i]   = 0;
                m_green[i] = 0;
                m_ovf[i]   = 0;
            end
            m_err = 0;
        end else begin
            if (a_l == X || b_l == X || (a_l == G && b_l == G)) m_err = 1;
            road_step(0, aa, a_l);
            road_step(1, ab, b_l);
        end
    endtask

    task automatic compare_all();
        check("cnt_a", int'(bus.cnt_a), m_cnt[0]);
        check("cnt_b", int'(bus.cnt_b), m_cnt[1]);
        check("ta", int'(bus.ta), int'(m_cnt[0] != 0));
        check("tb", int'(bus.tb), int'(m_cnt[1] != 0));
        check("ovf_a", int'(bus.ovf_a), int'(m_ovf[0]));
        check("ovf_b", int'(bus.ovf_b), int'(m_ovf[1]));
        check("err", int'(bus.err), int'(m_err));
    endtask

    task automatic cyc(input bit r, input bit aa, input bit ab,
                       input logic [1:0] a_l, input logic [1:0] b_l);
        @(negedge clk);
        rst       = r;
        bus.arr_a = aa;
        bus.arr_b = ab;
        bus.la    = a_l;
        bus.lb    = b_l;
        model_step(r, aa, ab, a_l, b_l);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    function automatic logic [1:0] rand_light();
        int v;
        v = $urandom_range(0, 9);
        if (v < 5) return G;
        if (v == 5) return Y;
        if (v < 9) return R;
        return X;
    endfunction

    initial begin
        int phase;
        int n;
        bit saw_bg;
        bit done;
        bit fired;

        rst       = 1'b0;
        bus.arr_a = 1'b0;
        bus.arr_b = 1'b0;
        bus.la    = R;
        bus.lb    = R;
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_green[i] = 0; m_ovf[i] = 0;
        end
        m_err = 0;

        // reset with arrivals pulsing
        cyc(0, 1, 0, G, R);
        cyc(0, 1, 1, X, G);
        check("rst_cnt_a", int'(bus.cnt_a), 0);
        cyc(1, 0, 0, R, R);
        check("rel_cnt_a", int'(bus.cnt_a), 0);

        // three arrivals on red, then drain on green
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, R, R);
        check("fill3", int'(bus.cnt_a), 3);
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, G, R);
        check("drain3", int'(bus.ta), 0);

        // arrival on the departure cycle
        cyc(1, 1, 0, R, R);
        cyc(1, 1, 0, R, R);
        fired = 0;
        for (int i = 0; i < 8; i++) begin
            bit a;
            a = !fired && (m_green[0] == DEP - 1);
            if (a) fired = 1;
            cyc(1, a, 0, G, R);
        end
        check("coinc_fired", int'(fired), 1);

        // saturation on B
        cyc(0, 0, 0, R, R);
        for (int i = 0; i < 16; i++) cyc(1, 0, 1, R, R);
        check("sat_cnt_b", int'(bus.cnt_b), MAXC);
        check("sat_ovf_b", int'(bus.ovf_b), 1);
        for (int i = 0; i < 16 * DEP + 2; i++) cyc(1, 0, 0, R, G);
        check("sat_drain", int'(bus.cnt_b), 0);
        check("sat_ovf_hold", int'(bus.ovf_b), 1);

        // green interrupted by yellow, then illegal code
        cyc(0, 0, 0, R, R);
        cyc(1, 1, 0, R, R);
        cyc(1, 0, 0, G, R);
        cyc(1, 0, 0, G, R);
        cyc(1, 0, 0, Y, R);
        cyc(1, 0, 0, G, R);
        cyc(1, 0, 0, G, R);
        check("yel_hold", int'(bus.cnt_a), 1);
        cyc(1, 0, 0, G, R);
        check("yel_restart", int'(bus.cnt_a), 0);
        cyc(1, 0, 0, X, R);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, R, R);
        check("err_sticky", int'(bus.err), 1);

        // reset mid-departure
        cyc(0, 0, 0, R, R);
        cyc(1, 1, 0, R, R);
        cyc(1, 1, 0, R, R);
        cyc(1, 0, 0, G, R);
        cyc(1, 0, 0, G, R);
        cyc(0, 1, 0, G, R);
        for (int i = 0; i < 5; i++) cyc(1, i == 0, 0, G, R);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            bit r;
            r = ($urandom_range(0, 99) != 0);
            cyc(r, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                rand_light(), rand_light());
        end

        // closed loop with a simple controller, arrivals on B only
        cyc(0, 0, 0, R, R);
        phase  = 0;
        saw_bg = 0;
        done   = 0;
        n      = 0;
        while (!done && n < 400) begin
            logic [1:0] a_l, b_l;
            case (phase)
                0:       begin a_l = G; b_l = R; end
                1:       begin a_l = Y; b_l = R; end
                2:       begin a_l = R; b_l = G; end
                default: begin a_l = R; b_l = Y; end
            endcase
            if (phase == 2) saw_bg = 1;
            cyc(1, 0, (n < 30) && ($urandom_range(0, 3) == 0), a_l, b_l);
            case (phase)
                0:       if (bus.tb) phase = 1;
                1:       phase = 2;
                2:       if (!bus.tb) phase = 3;
                default: phase = 0;
            endcase
            n++;
            if (n > 30 && phase == 0 && !bus.tb) done = 1;
        end
        check("loop_done", int'(done), 1);
        check("loop_bgreen", int'(saw_bg), 1);
        check("loop_tb", int'(bus.tb), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
